// File: rtl/programmable_gate_array.sv
// Programmable bitwise logic unit with valid/ready streams.
// Bitwise mode maps each beat to one result; fold mode chains a packet.
module programmable_gate_array #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_op,
    input  logic             cfg_fold,
    output logic             cfg_busy,
    output logic [2:0]       op_q,
    output logic             fold_q,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [CNT_W-1:0] out_len
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] fx;
    logic [WIDTH-1:0] fy;
    logic [WIDTH-1:0] res;
    logic             accept;
    logic             chained;

    function automatic logic [WIDTH-1:0] gate(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] r;
        unique case (op)
            3'b000: r = x & y;
            3'b001: r = x | y;
            3'b010: r = ~(x & y);
            3'b011: r = ~(x | y);
            3'b100: r = x ^ y;
            3'b101: r = ~(x ^ y);
            3'b110: r = x;
            3'b111: r = ~x;
        endcase
        return r;
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign cfg_busy = (state == ACCUM);
    assign cnt_inc  = (&cnt) ? cnt : cnt + CNT_W'(1);

    // Inside a packet the running value replaces a, and a replaces b.
    assign chained = fold_q && (state == ACCUM);
    assign fx      = chained ? acc : in_a;
    assign fy      = chained ? in_a : in_b;
    assign res     = gate(op_q, fx, fy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= 3'b000;
            fold_q    <= 1'b0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_len   <= '0;
            acc       <= '0;
            cnt       <= '0;
            state     <= IDLE;
        end else begin
            if (cfg_we && !cfg_busy) begin
                op_q   <= cfg_op;
                fold_q <= cfg_fold;
            end
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (!fold_q || (state == IDLE && in_last)) begin
                    out_y     <= res;
                    out_len   <= CNT_W'(1);
                    out_valid <= 1'b1;
                end else if (state == IDLE) begin
                    acc   <= res;
                    cnt   <= CNT_W'(1);
                    state <= ACCUM;
                end else if (in_last) begin
                    out_y     <= res;
                    out_len   <= cnt_inc;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end else begin
                    acc <= res;
                    cnt <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_programmable_gate_array.sv
// Bench for programmable_gate_array: directed steps plus random traffic
// against a packet-level reference model, on CNT_W=8 and CNT_W=2 copies.
module tb_programmable_gate_array;

    logic       clk;
    logic       rst_n;
    logic       cfg_we;
    logic [2:0] cfg_op;
    logic       cfg_fold;
    logic       in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_last;
    logic       out_ready;

    logic       cfg_busy, cfg_busy2;
    logic [2:0] op_q, op_q2;
    logic       fold_q, fold_q2;
    logic       in_ready, in_ready2;
    logic       out_valid, out_valid2;
    logic [7:0] out_y, out_y2;
    logic [7:0] out_len;
    logic [1:0] out_len2;

    int checks   = 0;
    int failures = 0;
    int rx_cnt   = 0;

    logic [2:0] m_op;
    logic       m_fold;
    logic       m_valid;
    logic [7:0] m_y;
    int         m_len8;
    int         m_len2;
    logic [7:0] pkt_a[$];
    logic [7:0] pkt_b0;

    programmable_gate_array #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_op(cfg_op), .cfg_fold(cfg_fold),
        .cfg_busy(cfg_busy), .op_q(op_q), .fold_q(fold_q),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_len(out_len)
    );

    programmable_gate_array #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_op(cfg_op), .cfg_fold(cfg_fold),
        .cfg_busy(cfg_busy2), .op_q(op_q2), .fold_q(fold_q2),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_y(out_y2), .out_len(out_len2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] fn(input logic [2:0] op,
                                      input logic [7:0] x,
                                      input logic [7:0] y);
        case (op)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return ~(x & y);
            3'd3: return ~(x | y);
            3'd4: return x ^ y;
            3'd5: return ~(x ^ y);
            3'd6: return x;
            default: return ~x;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        m_op = 3'd0;
        m_fold = 1'b0;
        m_valid = 1'b0;
        m_y = 8'h00;
        m_len8 = 0;
        m_len2 = 0;
        pkt_a.delete();
    endtask

    task automatic mload(input logic [7:0] y, input int n);
        m_y = y;
        m_len8 = (n > 255) ? 255 : n;
        m_len2 = (n > 3) ? 3 : n;
        m_valid = 1'b1;
    endtask

    task automatic chk_out();
        chk("out_valid", out_valid, m_valid);
        chk("out_valid2", out_valid2, m_valid);
        chk("out_y", out_y, m_y);
        chk("out_y2", out_y2, m_y);
        chk("out_len", out_len, m_len8);
        chk("out_len2", out_len2, m_len2);
        chk("op_q", op_q, m_op);
        chk("fold_q", fold_q, m_fold);
        chk("cfg_busy", cfg_busy, pkt_a.size() != 0);
        chk("cfg_busy2", cfg_busy2, pkt_a.size() != 0);
    endtask

    task automatic cyc(input bit v, input logic [7:0] a, input logic [7:0] b,
                       input bit last, input bit ordy, input bit we,
                       input logic [2:0] cop, input bit cfold,
                       output bit took);
        bit         busy;
        logic [2:0] op;
        logic [7:0] r;
        in_valid = v;
        in_a = a;
        in_b = b;
        in_last = last;
        out_ready = ordy;
        cfg_we = we;
        cfg_op = cop;
        cfg_fold = cfold;
        #1;
        chk("in_ready", in_ready, !m_valid || ordy);
        chk("in_ready2", in_ready2, !m_valid || ordy);
        if (out_valid && out_ready) rx_cnt++;
        @(posedge clk);
        took = v && (!m_valid || ordy);
        busy = pkt_a.size() != 0;
        op = m_op;
        if (ordy) m_valid = 1'b0;
        if (took) begin
            if (!m_fold) begin
                mload(fn(op, a, b), 1);
            end else begin
                if (pkt_a.size() == 0) pkt_b0 = b;
                pkt_a.push_back(a);
                if (last) begin
                    r = fn(op, pkt_a[0], pkt_b0);
                    for (int i = 1; i < pkt_a.size(); i++) r = fn(op, r, pkt_a[i]);
                    mload(r, pkt_a.size());
                    pkt_a.delete();
                end
            end
        end
        if (we && !busy) begin
            m_op = cop;
            m_fold = cfold;
        end
        #1;
        chk_out();
    endtask

    task automatic cfg(input logic [2:0] op, input bit fold);
        bit t;
        cyc(0, 8'h00, 8'h00, 0, 1, 1, op, fold, t);
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b, input bit last);
        bit t;
        cyc(1, a, b, last, 1, 0, 3'd0, 0, t);
        chk("beat_taken", t, 1);
    endtask

    logic [7:0] tab[8];
    logic [7:0] bp_a[4];
    logic [7:0] bp_b[4];

    initial begin
        bit t;
        int idx;
        tab = '{8'h48, 8'hDE, 8'hB7, 8'h21, 8'h96, 8'h69, 8'hCA, 8'h35};
        rst_n = 1'b0;
        cfg_we = 0; cfg_op = 0; cfg_fold = 0;
        in_valid = 0; in_a = 0; in_b = 0; in_last = 0; out_ready = 0;
        mreset();
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk_out();
        rst_n = 1'b1;

        // Every bitwise function on the reference operands.
        for (int i = 0; i < 8; i++) begin
            cfg(3'(i), 0);
            beat(8'hCA, 8'h5C, 0);
            chk("tab_y", out_y, tab[i]);
            chk("tab_len", out_len, 1);
        end

        // Stalled output: the source holds each beat until accepted.
        cfg(3'd4, 0);
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = 8'($urandom);
            bp_b[i] = 8'($urandom);
        end
        idx = 0;
        rx_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (idx < 4)
                cyc(1, bp_a[idx], bp_b[idx], 0, (c >= 4), 0, 3'd0, 0, t);
            else
                cyc(0, 8'h00, 8'h00, 0, 1, 0, 3'd0, 0, t);
            if (t) idx++;
        end
        chk("bp_sent", idx, 4);
        chk("bp_recv", rx_cnt, 4);

        // XOR fold of three beats.
        cfg(3'd4, 1);
        beat(8'h01, 8'h02, 0);
        beat(8'h04, 8'($urandom), 0);
        beat(8'h08, 8'($urandom), 1);
        chk("fold_y", out_y, 8'h0F);
        chk("fold_len", out_len, 3);

        // Config write inside a packet is dropped.
        beat(8'h11, 8'h22, 0);
        cyc(0, 8'h00, 8'h00, 0, 1, 1, 3'd0, 1, t);
        chk("busy_op", op_q, 3'd4);
        cyc(1, 8'h44, 8'h00, 1, 1, 1, 3'd0, 1, t);
        chk("busy_y", out_y, 8'h77);
        cyc(1, 8'h5A, 8'h0F, 1, 1, 1, 3'd1, 1, t);
        chk("same_cyc_y", out_y, 8'h55);
        chk("same_cyc_op", op_q, 3'd1);
        beat(8'h5A, 8'h0F, 1);
        chk("next_op_y", out_y, 8'h5F);

        // Five-beat OR fold saturates the narrow counter.
        cfg(3'd1, 1);
        beat(8'h01, 8'h20, 0);
        beat(8'h02, 8'h00, 0);
        beat(8'h04, 8'h00, 0);
        beat(8'h08, 8'h00, 0);
        beat(8'h10, 8'h00, 1);
        chk("sat_y", out_y2, 8'h3F);
        chk("sat_len2", out_len2, 2'd3);
        chk("sat_len8", out_len, 5);

        // Asynchronous reset while a packet is open.
        cfg(3'd4, 1);
        beat(8'h0F, 8'hF0, 0);
        in_valid = 1; in_a = 8'h33; in_last = 0;
        #2;
        rst_n = 1'b0;
        #1;
        mreset();
        chk_out();
        in_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cfg(3'd4, 1);
        beat(8'h01, 8'h02, 0);
        beat(8'h04, 8'h00, 1);
        chk("post_rst_y", out_y, 8'h07);
        chk("post_rst_len", out_len, 2);

        // Random traffic; config writes only on idle input cycles.
        for (int c = 0; c < 400; c++) begin
            bit v;
            bit we;
            v = ($urandom_range(0, 3) != 0);
            we = !v && ($urandom_range(0, 5) == 0);
            cyc(v, 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) != 0), we, 3'($urandom),
                1'($urandom), t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/programmable_gate_array.md
# programmable_gate_array

Registered, parametrised programmable logic unit. Applies one of eight configurable 2-input bitwise functions across WIDTH-bit operand vectors, or folds a multi-beat packet into a single result. Operands and results move over valid/ready streams. Op codes 000–011 keep the original 2-bit programmable-gate encoding (AND, OR, NAND, NOR), so existing configuration software carries over unchanged.

## Interface
- WIDTH, 8, operand/result bit width (≥1)
- CNT_W, 8, width of packet beat counter (≥1)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  configuration write strobe
- cfg_op  in  3  function code to load
- cfg_fold  in  1  mode to load: 0 = bitwise, 1 = packet fold
- cfg_busy  out  1  high while a fold packet is in progress; cfg writes are ignored
- op_q  out  3  active function code
- fold_q  out  1  active mode
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid & in_ready
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_last  in  1  final beat of packet (fold mode only; ignored in bitwise mode)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_y  out  WIDTH  result
- out_len  out  CNT_W  beats in result (saturating)

## Operation
- Function f(x,y), per bit: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 x (pass), 111 ~x.
- Config: on cfg_we & !cfg_busy, the next edge loads op_q←cfg_op and fold_q←cfg_fold. A cfg_we while cfg_busy is dropped; it is not queued.
- Beat accept: in_ready = !out_valid | out_ready, in both modes.
- Bitwise mode: each accepted beat loads out_y←f(in_a,in_b), out_len←1, out_valid←1.
- Fold mode FSM:
  - IDLE, accepted beat with in_last=0: acc←f(in_a,in_b), cnt←1, go to ACCUM.
  - IDLE, accepted beat with in_last=1: out_y←f(in_a,in_b), out_len←1, out_valid←1. Stay in IDLE.
  - ACCUM, accepted beat: acc←f(acc,in_a); in_b is ignored. cnt increments and saturates at 2^CNT_W−1.
  - ACCUM, accepted beat with in_last=1: out_y←f(acc,in_a), out_len←sat(cnt+1), out_valid←1, go to IDLE.
  - cfg_busy = (state == ACCUM).
- Output: out_valid clears on out_ready when no new result is loaded in the same cycle. A simultaneous drain and load keeps out_valid high with the new data.
- Any beat uses the op_q/fold_q values current in its cycle. A cfg write in the same cycle as a beat affects only later beats.

## Timing
- Reset values: op_q=000, fold_q=0, out_valid=0, out_y=0, out_len=0, acc=0, cnt=0, state IDLE, cfg_busy=0.
- in_ready is combinational from out_valid/out_ready. It is 1 after reset.
- Bitwise latency: 1 cycle from accept to out_valid. Full throughput of 1 beat/cycle while out_ready=1.
- Fold latency: 1 cycle from accept of the last beat to out_valid.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0 and out_y/out_len stay stable.
- Reset mid-packet: the partial accumulation is discarded and every output returns to its reset value immediately (asynchronous).
- cnt saturation: packets longer than 2^CNT_W−1 beats report out_len=2^CNT_W−1. The fold result is still correct.

## Test plan
- Reset, then bitwise op 000–111 with a=8'hCA, b=8'h5C, out_ready=1 -> out_y = 48, DE, B7, 21, 96, 69, CA, 35; one cycle after each accept; out_len=1.
- Back-to-back bitwise beats with out_ready held 0 for 3 cycles -> in_ready=0 and out_y frozen; on release, no beat is lost or duplicated.
- Fold mode, op XOR, beats (a,b) = (01,02), (04,xx), (08,xx with last) -> single out_y=8'h0F, out_len=3; cfg_busy high from the cycle after beat 1 until the cycle after the last beat.
- cfg_we during ACCUM (op→AND) -> ignored; the packet completes with XOR. cfg_we in IDLE together with a single-beat last packet -> the beat uses the old op; the next beat uses the new op.
- CNT_W=2, fold OR, a 5-beat packet -> out_len=3 (saturated), out_y = OR of the a/b terms.
- Assert rst_n low during beat 2 of a fold packet -> all outputs go to reset values immediately; the next packet starts cleanly from IDLE.
